alu_rf_sequencer: RTL
=====================

Name: alu_rf_sequencer

Overview:
Command-driven controller that sequences the 32-bit ALU + register-file datapath. It accepts one register-to-register operation per handshake (rs, rt, rd, ALU control, repeat count) and drives the RF read/write addresses, the ALU control and the RF write enable on a fixed 3-cycle schedule. It checks the ALU error flags before committing a result and returns a one-cycle response carrying status. It sits between the instruction source (decoder/testbench) and the ALU+RF pair.

Parameters:
REP_W, 4, width of the repeat field; the operation executes cmd_rep+1 times
ZERO_REG_RO, 1, when 1, writes to register 0 are suppressed (write_enabled held 0) and are not errors

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_rs / cmd_rt / cmd_rd  in  5 each  source s, source t, destination register
cmd_ctrl  in  4  ALU control code
cmd_rep  in  REP_W  extra iterations
read_addr_s / read_addr_t / write_addr  out  5 each  to RF
control  out  4  to ALU
write_enabled  out  1  to RF
alu_zero / alu_cout / alu_overflow / alu_invalid  in  1 each  ALU flags
rsp_valid  out  1  one-cycle completion pulse
rsp_zero / rsp_cout  out  1 each  flags of last executed iteration
rsp_err  out  2  bit0 overflow, bit1 invalid control; 0 = clean
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including cmd_ready, write_enabled, rsp_*, busy and all address/control outputs. Leaving reset sets cmd_ready=1 on the first clock edge.
- Reset mid-operation: write_enabled drops immediately (async), the command is discarded and no rsp_valid is produced.
- Datapath timing: RF reads are combinational. The ALU registers its result and flags on the rising edge. The RF writes on the rising edge when write_enabled=1.
- FSM states: IDLE, ISSUE, EXEC, WRITE, RESP.
- IDLE: cmd_ready=1. On handshake, latch rs, rt, rd, ctrl; load iter_cnt=cmd_rep; clear the error register; go to ISSUE.
- ISSUE: drive read_addr_s (rs on the first iteration, rd on later ones), read_addr_t=rt, control=ctrl, write_addr=rd. Go to EXEC.
- EXEC: outputs held. At the end of the cycle, register the ALU flags into zero_q, cout_q, err_q. Go to WRITE.
- WRITE: write_enabled=1 only if err_q==0 and not (ZERO_REG_RO && rd==0).
  - If err_q!=0 or iter_cnt==0, go to RESP.
  - Otherwise decrement iter_cnt and go to ISSUE.
- RESP: rsp_valid=1 for exactly one cycle with rsp_zero, rsp_cout and rsp_err; go to IDLE. rsp_* other than rsp_valid hold their values until the next RESP.
- Latency: 3 cycles per iteration plus 1 response cycle, so a single operation is handshake + 4 cycles to rsp_valid. Next accept is possible the cycle after RESP.
- Error on any iteration: that iteration's write is suppressed, remaining iterations are abandoned, rsp_err is reported.
- cmd_rep = 2^REP_W-1 executes 2^REP_W iterations; iter_cnt must not wrap.
- cmd_valid while busy is ignored and must be held by the source.
- Address and control outputs hold their last values in IDLE/RESP. write_enabled=0 in every state except a qualifying WRITE.

Optional Feature:
Macro SEQ_STATS_EN.
- Defined: adds outputs stat_ops (32-bit, counts committed writes) and stat_errs (16-bit, counts responses with rsp_err!=0). Both reset to 0 and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then preload r1=5, r2=7. Command rs=1, rt=2, rd=3, ctrl=ADD, rep=0 -> write_enabled high exactly 1 cycle (cycle 3 after accept), r3=12; rsp_valid at cycle 4, rsp_err=0, rsp_zero=0.
- r1=3, r2=3, ctrl=SUB, rd=4 -> r4=0, rsp_zero=1; cmd_ready low cycles 1-4, high at cycle 5.
- r1=1, r2=2, rd=5, ctrl=ADD, rep=3 -> 4 writes 3 cycles apart; r5 sequence 3,5,7,9; rsp_valid at cycle 13.
- r1=0x7FFFFFFF, r2=1, ctrl=ADD, rep=2 -> no write, rsp_err=2'b01 after the first iteration; a separate command with an invalid ctrl code -> rsp_err=2'b10, no write.
- rd=0 with ZERO_REG_RO=1 -> write_enabled never asserted, rsp_err=0. Assert reset_n low during EXEC of a command -> all outputs 0 immediately, no rsp_valid, and the next command executes normally.

Source files
------------

// File: rtl/alu_rf_sequencer.sv
// Sequencer for the ALU + register-file datapath: one command per handshake, 3-cycle issue/exec/write schedule.
// Optional SEQ_STATS_EN adds saturating stat_ops / stat_errs counters.
module alu_rf_sequencer #(
    parameter int REP_W       = 4,
    parameter bit ZERO_REG_RO = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_rs,
    input  logic [4:0]       cmd_rt,
    input  logic [4:0]       cmd_rd,
    input  logic [3:0]       cmd_ctrl,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [4:0]       read_addr_s,
    output logic [4:0]       read_addr_t,
    output logic [4:0]       write_addr,
    output logic [3:0]       control,
    output logic             write_enabled,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    input  logic             alu_invalid,
    output logic             rsp_valid,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic [1:0]       rsp_err,
`ifdef SEQ_STATS_EN
    output logic [31:0]      stat_ops,
    output logic [15:0]      stat_errs,
`endif
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, EXEC, WRITE, RESP} state_t;

    state_t           state_reg, state_next;
    logic             ready_reg;
    logic [4:0]       addr_s_reg, addr_t_reg, waddr_reg;
    logic [3:0]       control_reg;
    logic [REP_W-1:0] iter_reg;
    logic             zero_q, cout_q;
    logic [1:0]       err_q;
    logic             rsp_zero_reg, rsp_cout_reg;
    logic [1:0]       rsp_err_reg;
    logic             accept;

    assign accept      = cmd_valid && ready_reg && (state_reg == IDLE);
    assign cmd_ready   = ready_reg;
    assign read_addr_s = addr_s_reg;
    assign read_addr_t = addr_t_reg;
    assign write_addr  = waddr_reg;
    assign control     = control_reg;
    assign rsp_zero    = rsp_zero_reg;
    assign rsp_cout    = rsp_cout_reg;
    assign rsp_err     = rsp_err_reg;

    always_comb begin
        state_next    = state_reg;
        write_enabled = 1'b0;
        rsp_valid     = 1'b0;
        busy          = (state_reg != IDLE);
        case (state_reg)
            IDLE:  if (accept) state_next = ISSUE;
            ISSUE: state_next = EXEC;
            EXEC:  state_next = WRITE;
            WRITE: begin
                // err_q was captured from this iteration's flags at the end of EXEC
                write_enabled = (err_q == 2'b00) && !(ZERO_REG_RO && (waddr_reg == 5'd0));
                if ((err_q != 2'b00) || (iter_reg == '0))
                    state_next = RESP;
                else
                    state_next = ISSUE;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            ready_reg    <= 1'b0;
            addr_s_reg   <= '0;
            addr_t_reg   <= '0;
            waddr_reg    <= '0;
            control_reg  <= '0;
            iter_reg     <= '0;
            zero_q       <= 1'b0;
            cout_q       <= 1'b0;
            err_q        <= '0;
            rsp_zero_reg <= 1'b0;
            rsp_cout_reg <= 1'b0;
            rsp_err_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
            if (accept) begin
                addr_s_reg  <= cmd_rs;
                addr_t_reg  <= cmd_rt;
                waddr_reg   <= cmd_rd;
                control_reg <= cmd_ctrl;
                iter_reg    <= cmd_rep;
                err_q       <= '0;
            end
            if (state_reg == EXEC) begin
                zero_q <= alu_zero;
                cout_q <= alu_cout;
                err_q  <= {alu_invalid, alu_overflow};
            end
            if (state_reg == WRITE) begin
                if (state_next == ISSUE) begin
                    // later iterations accumulate into the destination
                    iter_reg   <= iter_reg - REP_W'(1);
                    addr_s_reg <= waddr_reg;
                end else begin
                    rsp_zero_reg <= zero_q;
                    rsp_cout_reg <= cout_q;
                    rsp_err_reg  <= err_q;
                end
            end
        end
    end

`ifdef SEQ_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else begin
            if (write_enabled && (stat_ops != '1))
                stat_ops <= stat_ops + 32'd1;
            if (rsp_valid && (rsp_err_reg != 2'b00) && (stat_errs != '1))
                stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule
